// File: rtl/fta_resp_sched_if.sv
// Shared response types and the merged-response bus interface
// for the fta round-robin response scheduler.
package fta_resp_pkg;
  typedef struct packed {
    logic         ack;
    logic         stall;
    logic         next;
    logic [3:0]   pri;
    logic [7:0]   tid;
    logic [127:0] dat;
  } resp128_t;

  typedef resp128_t fta_cmd_response128_t;
endpackage

interface fta_resp_if #(
  parameter int CHANNELS = 8
);
  import fta_resp_pkg::*;

  resp128_t [CHANNELS-1:0] resp;
  logic [CHANNELS-1:0]     resp_stall_o;
  fta_cmd_response128_t    resp_o;
  logic                    resp_rdy_i;

  modport slave (
    input  resp,
    input  resp_rdy_i,
    output resp_stall_o,
    output resp_o
  );

  modport master (
    output resp,
    output resp_rdy_i,
    input  resp_stall_o,
    input  resp_o
  );
endinterface

// File: rtl/fta_resp_sched.sv
// Round-robin merge of CHANNELS response streams, each behind
// a DEPTH-entry FIFO, into one registered response output.
module fta_resp_sched
  import fta_resp_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  fta_resp_if.slave           bus,
  output logic [CHANNELS-1:0] ovf_o,
  input  logic                ovf_clr_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(CHANNELS);

  localparam fta_cmd_response128_t IDLE = '{
    ack: 1'b0, stall: 1'b0, next: 1'b0,
    pri: 4'hF, tid: '0, dat: '0
  };

  typedef enum logic {EMPTY, FULL} state_e;

  resp128_t       mem_q [CHANNELS][DEPTH];
  logic [PW-1:0]  wr_q  [CHANNELS];
  logic [PW-1:0]  rd_q  [CHANNELS];
  logic [CW-1:0]  cnt_q [CHANNELS];
  logic [CW-1:0]  cnt_d [CHANNELS];

  logic [CHANNELS-1:0] ovf_q, ovf_d;
  logic [CHANNELS-1:0] nonempty, acc, pop, drop;

  state_e               state_q, state_d;
  fta_cmd_response128_t out_q, out_d;
  logic [IW-1:0]        rr_q, rr_d;
  logic [IW-1:0]        gnt, cand;
  logic                 found, take;

  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      nonempty[n]        = cnt_q[n] != '0;
      bus.resp_stall_o[n] = cnt_q[n] >= CW'(DEPTH - 1);
    end
  end

  // Search starts one past the last grant, wrapping.
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    cand  = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      cand = IW'((int'(rr_q) + i) % CHANNELS);
      if (!found && nonempty[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
  end

  assign take = found &&
                (state_q == EMPTY || bus.resp_rdy_i);

  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      pop[n]  = take && (gnt == IW'(n));
      acc[n]  = bus.resp[n].ack &&
                (cnt_q[n] != CW'(DEPTH) || pop[n]);
      drop[n] = bus.resp[n].ack && !acc[n];
      cnt_d[n] = cnt_q[n] + CW'(acc[n]) - CW'(pop[n]);
    end
    ovf_d = (ovf_clr_i ? '0 : ovf_q) | drop;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        wr_q[n]  <= '0;
        rd_q[n]  <= '0;
        cnt_q[n] <= '0;
      end
    end else begin
      ovf_q <= ovf_d;
      for (int n = 0; n < CHANNELS; n++) begin
        if (acc[n]) wr_q[n] <= wr_q[n] + PW'(1);
        if (pop[n]) rd_q[n] <= rd_q[n] + PW'(1);
        cnt_q[n] <= cnt_d[n];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int n = 0; n < CHANNELS; n++) begin
      if (rst && acc[n]) mem_q[n][wr_q[n]] <= bus.resp[n];
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    rr_d    = rr_q;
    unique case (state_q)
      EMPTY: begin
        if (found) state_d = FULL;
      end
      FULL: begin
        if (bus.resp_rdy_i && !found) begin
          state_d = EMPTY;
          out_d   = IDLE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (take) begin
      out_d       = mem_q[gnt][rd_q[gnt]];
      out_d.ack   = 1'b1;
      out_d.stall = 1'b0;
      out_d.next  = 1'b0;
      rr_d        = gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      out_q   <= IDLE;
      rr_q    <= IW'(CHANNELS - 1);
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.resp_o = out_q;
  assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_fta_resp_sched.sv
// Directed bench for fta_resp_sched: reset, latency, round-robin,
// back-pressure/overflow, full push+pop and mid-run reset.
module tb_fta_resp_sched;
  import fta_resp_pkg::*;

  localparam int CH = 8;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ovf_clr;
  logic [CH-1:0] ovf;
  int            total = 0;
  int            bad   = 0;

  fta_resp_if #(.CHANNELS(CH)) bus ();

  fta_resp_sched #(.CHANNELS(CH), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ovf_o     (ovf),
    .ovf_clr_i (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic resp128_t mk(input logic [127:0] d,
                                  input logic [7:0] t);
    resp128_t r;
    r       = '0;
    r.ack   = 1'b1;
    r.stall = 1'b1;
    r.next  = 1'b1;
    r.pri   = 4'h3;
    r.tid   = t;
    r.dat   = d;
    return r;
  endfunction

  task automatic chk_beat(input string tag,
                          input logic [127:0] d);
    chk({tag, "_ack"}, 128'(bus.resp_o.ack), 128'd1);
    chk({tag, "_dat"}, bus.resp_o.dat, d);
  endtask

  initial begin
    rst            = 1'b0;
    ovf_clr        = 1'b0;
    bus.resp       = '0;
    bus.resp_rdy_i = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_ack", 128'(bus.resp_o.ack), 128'd0);
    chk("rst_pri", 128'(bus.resp_o.pri), 128'hF);
    chk("rst_ovf", 128'(ovf), 128'd0);
    chk("rst_stall", 128'(bus.resp_stall_o), 128'd0);
    rst = 1'b1;

    // Single beat latency
    bus.resp[3] = mk(128'hA5, 8'h33);
    bus.resp_rdy_i = 1'b1;
    tick();
    bus.resp = '0;
    chk("s1_e0_ack", 128'(bus.resp_o.ack), 128'd0);
    tick();
    chk_beat("s1_e1", 128'hA5);
    chk("s1_tid", 128'(bus.resp_o.tid), 128'h33);
    chk("s1_pri", 128'(bus.resp_o.pri), 128'h3);
    chk("s1_sn", 128'({bus.resp_o.stall, bus.resp_o.next}),
        128'd0);
    tick();
    chk("s1_e2_ack", 128'(bus.resp_o.ack), 128'd0);
    chk("s1_e2_pri", 128'(bus.resp_o.pri), 128'hF);

    // Round robin from a fresh pointer
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.resp[0] = mk(128'h01, 8'h0);
    bus.resp[2] = mk(128'h21, 8'h2);
    bus.resp[5] = mk(128'h51, 8'h5);
    tick();
    bus.resp[0] = mk(128'h02, 8'h0);
    bus.resp[2] = mk(128'h22, 8'h2);
    bus.resp[5] = mk(128'h52, 8'h5);
    tick();
    bus.resp = '0;
    chk_beat("rr0", 128'h01);
    tick();
    chk_beat("rr1", 128'h21);
    tick();
    chk_beat("rr2", 128'h51);
    tick();
    chk_beat("rr3", 128'h02);
    tick();
    chk_beat("rr4", 128'h22);
    tick();
    chk_beat("rr5", 128'h52);
    tick();
    chk("rr_end", 128'(bus.resp_o.ack), 128'd0);

    // Back-pressure and overflow on channel 1
    bus.resp_rdy_i = 1'b0;
    bus.resp[6] = mk(128'hEE, 8'h6);
    tick();
    bus.resp[6] = '0;
    tick();
    chk_beat("bp_hold0", 128'hEE);
    for (int k = 1; k <= 5; k++) begin
      bus.resp[1] = mk(128'(8'h10 + k), 8'h1);
      tick();
      chk_beat("bp_hold", 128'hEE);
      chk("bp_stall", 128'(bus.resp_stall_o[1]),
          128'(k >= 3));
      chk("bp_ovf", 128'(ovf), (k == 5) ? 128'h2 : 128'h0);
    end
    bus.resp[1] = mk(128'h16, 8'h1);
    ovf_clr = 1'b1;
    tick();
    chk("ovf_setwins", 128'(ovf), 128'h2);
    bus.resp = '0;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 128'(ovf), 128'h0);
    chk_beat("bp_hold_end", 128'hEE);
    bus.resp_rdy_i = 1'b1;
    tick();
    chk_beat("bp_d0", 128'h11);
    chk("bp_d0_stall", 128'(bus.resp_stall_o[1]), 128'd1);
    tick();
    chk_beat("bp_d1", 128'h12);
    chk("bp_d1_stall", 128'(bus.resp_stall_o[1]), 128'd0);
    tick();
    chk_beat("bp_d2", 128'h13);
    tick();
    chk_beat("bp_d3", 128'h14);
    tick();
    chk("bp_dend", 128'(bus.resp_o.ack), 128'd0);

    // Full FIFO pushed and popped in one cycle
    bus.resp_rdy_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      bus.resp[4] = mk(128'(8'h40 + k), 8'h4);
      tick();
    end
    chk_beat("fp_hold", 128'h41);
    chk("fp_stall_full", 128'(bus.resp_stall_o[4]), 128'd1);
    bus.resp[4] = mk(128'h46, 8'h4);
    bus.resp_rdy_i = 1'b1;
    tick();
    bus.resp = '0;
    chk_beat("fp_d0", 128'h42);
    chk("fp_ovf", 128'(ovf), 128'h0);
    chk("fp_stall", 128'(bus.resp_stall_o[4]), 128'd1);
    for (int k = 3; k <= 6; k++) begin
      tick();
      chk_beat("fp_dn", 128'(8'h40 + k));
    end
    tick();
    chk("fp_end", 128'(bus.resp_o.ack), 128'd0);
    chk("fp_ovf_end", 128'(ovf), 128'h0);

    // Mid-run reset with queued and held beats
    bus.resp_rdy_i = 1'b0;
    bus.resp[1] = mk(128'hB1, 8'h1);
    bus.resp[3] = mk(128'hB3, 8'h3);
    bus.resp[7] = mk(128'hB7, 8'h7);
    tick();
    tick();
    bus.resp = '0;
    chk("mr_held", 128'(bus.resp_o.ack), 128'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus.resp_rdy_i = 1'b1;
    chk("mr_ack", 128'(bus.resp_o.ack), 128'd0);
    chk("mr_pri", 128'(bus.resp_o.pri), 128'hF);
    chk("mr_stall", 128'(bus.resp_stall_o), 128'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("mr_noack", 128'(bus.resp_o.ack), 128'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
